dibits_to_bytes: RTL and testbench

DIBITS_TO_BYTES -- requirements
Module: dibits_to_bytes

---
 rtl/dibits_to_bytes_pkg.sv | 17 +
 rtl/dibits_to_bytes.sv | 62 ++++++
 tb/tb_dibits_to_bytes.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dibits_to_bytes_pkg.sv
// Shared parameters and helpers for the dibit-to-byte assembler.
package dibits_to_bytes_pkg;

  localparam int unsigned BYTE_LEN_DEFAULT = 8;
  localparam int unsigned DIBIT_W          = 2;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dibits_to_bytes.sv
// Assembles LSB-first dibits into BYTE_LEN-bit words, with frame-end flush.
module dibits_to_bytes
  import dibits_to_bytes_pkg::*;
#(
  parameter int unsigned BYTE_LEN = BYTE_LEN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inclk,
  input  logic [DIBIT_W-1:0]        in,
  input  logic                      in_done,
  output logic [BYTE_LEN-1:0]       out,
  output logic                      outclk,
  output logic                      done
);

  localparam int unsigned DIBITS   = BYTE_LEN / 2;
  localparam int unsigned CNT_BITS = clog2(DIBITS);
  // A one-dibit word still needs a 1-bit counter register to exist.
  localparam int unsigned CNT_W    = (CNT_BITS > 0) ? CNT_BITS : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIBITS - 1);

  logic [BYTE_LEN-1:0] shift_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BYTE_LEN-1:0] shifted_c;

  // New dibit enters at the top so the first one ends up in bits [1:0].
  always_comb begin
    shifted_c = BYTE_LEN'({in, shift_q} >> DIBIT_W);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      out     <= '0;
      outclk  <= 1'b0;
      done    <= 1'b0;
    end else begin
      outclk <= 1'b0;
      done   <= 1'b0;
      if (inclk) begin
        if (cnt_q == LAST_CNT) begin
          out     <= shifted_c;
          outclk  <= 1'b1;
          cnt_q   <= '0;
          shift_q <= '0;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          shift_q <= shifted_c;
        end
      end
      // Frame end wins over any partial accumulation, after the dibit is taken.
      if (in_done) begin
        done    <= 1'b1;
        cnt_q   <= '0;
        shift_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dibits_to_bytes.sv
// Directed bench for dibits_to_bytes with a queue-based reference model.
module tb_dibits_to_bytes;

  localparam int unsigned BL = 8;
  localparam int unsigned NDIB = BL / 2;

  logic          clk;
  logic          rst;
  logic          inclk;
  logic [1:0]    din;
  logic          in_done;
  logic [BL-1:0] out;
  logic          outclk;
  logic          done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_outclk = 0;
  int n_done   = 0;

  dibits_to_bytes #(.BYTE_LEN(BL)) dut (
    .clk    (clk),
    .rst    (rst),
    .inclk  (inclk),
    .in     (din),
    .in_done(in_done),
    .out    (out),
    .outclk (outclk),
    .done   (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: collect accepted dibits of the current word, emit when full.
  logic [1:0]    acc_q[$];
  logic [BL-1:0] m_out;
  logic          m_outclk;
  logic          m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q.delete();
      m_out    = '0;
      m_outclk = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_outclk = 1'b0;
      m_done   = 1'b0;
      if (inclk === 1'b1) begin
        acc_q.push_back(din);
        if (acc_q.size() == NDIB) begin
          logic [BL-1:0] w;
          w = '0;
          for (int i = 0; i < int'(NDIB); i++) w = w | (BL'(acc_q[i]) << (2 * i));
          m_out    = w;
          m_outclk = 1'b1;
          acc_q.delete();
        end
      end
      if (in_done === 1'b1) begin
        m_done = 1'b1;
        acc_q.delete();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (outclk === 1'b1) n_outclk++;
    if (done === 1'b1) n_done++;
    check("cyc_out", 32'(out), 32'(m_out));
    check("cyc_outclk", 32'(outclk), 32'(m_outclk));
    check("cyc_done", 32'(done), 32'(m_done));
  end

  task automatic put(input logic [1:0] d);
    inclk = 1'b1;
    din   = d;
    @(posedge clk);
    #1;
    inclk = 1'b0;
    din   = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    inclk = 1'b0;
    din = 2'b00;
    in_done = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_out", 32'(out), 32'h0);
    check("rst_outclk", 32'(outclk), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    idle(2);
    rst = 1'b1;
    idle(1);

    // Four 2'b10 dibits -> 0xAA one cycle after the last.
    for (int i = 0; i < 3; i++) put(2'b10);
    check("aa_no_early", 32'(outclk), 32'h0);
    put(2'b10);
    check("aa_outclk", 32'(outclk), 32'h1);
    check("aa_out", 32'(out), 32'hAA);
    idle(1);
    check("aa_single", 32'(outclk), 32'h0);
    check("aa_hold", 32'(out), 32'hAA);

    // LSB-first ordering.
    put(2'b01); put(2'b00); put(2'b11); put(2'b10);
    check("b1_outclk", 32'(outclk), 32'h1);
    check("b1_out", 32'(out), 32'hB1);
    idle(1);

    // Back-to-back: pulses exactly four cycles apart.
    for (int i = 0; i < 8; i++) begin
      put(2'b10);
      check("b2b_outclk", 32'(outclk), (i == 3 || i == 7) ? 32'h1 : 32'h0);
    end
    check("b2b_out", 32'(out), 32'hAA);
    idle(1);

    // Idle gaps between dibits do not disturb assembly.
    base = n_outclk;
    put(2'b11); idle(3); put(2'b01); idle(3); put(2'b00); idle(3); put(2'b10);
    check("gap_out", 32'(out), 32'h87);
    idle(2);
    check("gap_pulses", 32'(n_outclk - base), 32'h1);

    // Partial word flushed by in_done; out untouched.
    put(2'b01); put(2'b01);
    in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0;
    check("flush_done", 32'(done), 32'h1);
    check("flush_outclk", 32'(outclk), 32'h0);
    check("flush_out", 32'(out), 32'h87);
    idle(1);
    check("flush_done_one", 32'(done), 32'h0);
    for (int i = 0; i < 4; i++) put(2'b11);
    check("ff_out", 32'(out), 32'hFF);
    idle(1);

    // Final dibit coincident with in_done: both strobes together.
    put(2'b00); put(2'b01); put(2'b10);
    inclk = 1'b1; din = 2'b11; in_done = 1'b1;
    @(posedge clk); #1;
    inclk = 1'b0; in_done = 1'b0;
    check("both_outclk", 32'(outclk), 32'h1);
    check("both_done", 32'(done), 32'h1);
    check("both_out", 32'(out), 32'hE4);

    // Dibit with in_done mid-word is discarded; next word restarts at [1:0].
    put(2'b11);
    inclk = 1'b1; din = 2'b11; in_done = 1'b1;
    @(posedge clk); #1;
    inclk = 1'b0; in_done = 1'b0;
    check("mid_done", 32'(done), 32'h1);
    check("mid_outclk", 32'(outclk), 32'h0);
    put(2'b00); put(2'b00); put(2'b00); put(2'b11);
    check("restart_out", 32'(out), 32'hC0);
    idle(1);

    // Reset mid-word: everything clears, strobes ignored while held.
    put(2'b10); put(2'b10); put(2'b10);
    rst = 1'b0;
    #1;
    check("mrst_out", 32'(out), 32'h0);
    inclk = 1'b1; din = 2'b11; in_done = 1'b1;
    base = n_outclk + n_done;
    idle(3);
    inclk = 1'b0; in_done = 1'b0;
    check("mrst_quiet", 32'(n_outclk + n_done - base), 32'h0);
    rst = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) put(2'b01);
    check("post_rst_partial", 32'(outclk), 32'h0);
    put(2'b01);
    check("post_rst_outclk", 32'(outclk), 32'h1);
    check("post_rst_out", 32'(out), 32'h55);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
